// File: rtl/omi_axi_pkg.sv
// omi_axi_pkg: bridge state encoding, AXI4 constants and the AxSIZE helper
package omi_axi_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    function automatic logic [2:0] size_of(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction
endpackage

// File: rtl/omi_axi_bridge_if.sv
// omi_axi_bridge_if: AXI4 memory bus between the bridge (master) and external memory (slave)
interface omi_axi_bridge_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    modport master (
        output araddr, arlen, arsize, arburst, arvalid, input arready,
        input rdata, rresp, rlast, rvalid, output rready,
        output awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bresp, bvalid, output bready
    );
    modport slave (
        input araddr, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready,
        input awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/omi_axi_bridge.sv
// omi_axi_bridge: turns one outstanding OMI request into an AXI4 read burst or single-beat write
module omi_axi_bridge
    import omi_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_MAX = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_mem_req,
    input  logic                    i_mem_wen,
    input  logic [ADDR_WIDTH-1:0]   i_mem_addr,
    input  logic [DATA_WIDTH/8-1:0] i_mem_ben,
    input  logic [DATA_WIDTH-1:0]   i_mem_data,
    input  logic [7:0]              i_mem_len,
    output logic                    o_mem_rdy,
    output logic                    o_mem_valid,
    output logic [DATA_WIDTH-1:0]   o_mem_data,
    output logic                    o_mem_err,
    omi_axi_bridge_if.master        m_axi
);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
    state_t                r_state;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic                  w_in_range;
    logic                  w_final;
    logic                  w_aw_done;
    logic                  w_w_done;
    assign w_addr = i_mem_addr & ALIGN_MASK;
    assign w_len = (i_mem_len == 8'd0) ? 8'd1 : (i_mem_len > 8'(LEN_MAX)) ? 8'(LEN_MAX) : i_mem_len;
    // beats past the requested length are drained silently until rlast
    assign w_in_range = r_beat < r_len;
    assign w_final = (r_beat + 8'd1) == r_len;
    assign w_aw_done = !m_axi.awvalid || m_axi.awready;
    assign w_w_done = !m_axi.wvalid || m_axi.wready;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_len <= '0;
            r_beat <= '0;
            o_mem_rdy <= 1'b1;
            o_mem_valid <= 1'b0;
            o_mem_data <= '0;
            o_mem_err <= 1'b0;
            m_axi.araddr <= '0;
            m_axi.arlen <= '0;
            m_axi.arsize <= '0;
            m_axi.arburst <= '0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready <= 1'b0;
            m_axi.awaddr <= '0;
            m_axi.awlen <= '0;
            m_axi.awsize <= '0;
            m_axi.awburst <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata <= '0;
            m_axi.wstrb <= '0;
            m_axi.wlast <= 1'b0;
            m_axi.wvalid <= 1'b0;
            m_axi.bready <= 1'b0;
        end else begin
            o_mem_valid <= 1'b0;
            o_mem_data <= '0;
            o_mem_err <= 1'b0;
            case (r_state)
                IDLE: if (i_mem_req) begin
                    o_mem_rdy <= 1'b0;
                    r_beat <= '0;
                    r_len <= w_len;
                    if (i_mem_wen) begin
                        m_axi.awaddr <= w_addr;
                        m_axi.awlen <= '0;
                        m_axi.awsize <= size_of(DATA_WIDTH);
                        m_axi.awburst <= BURST_INCR;
                        m_axi.awvalid <= 1'b1;
                        m_axi.wdata <= i_mem_data;
                        m_axi.wstrb <= i_mem_ben;
                        m_axi.wlast <= 1'b1;
                        m_axi.wvalid <= 1'b1;
                        r_state <= WR_REQ;
                    end else begin
                        m_axi.araddr <= w_addr;
                        m_axi.arlen <= w_len - 8'd1;
                        m_axi.arsize <= size_of(DATA_WIDTH);
                        m_axi.arburst <= BURST_INCR;
                        m_axi.arvalid <= 1'b1;
                        r_state <= RD_ADDR;
                    end
                end
                RD_ADDR: if (m_axi.arready) begin
                    m_axi.arvalid <= 1'b0;
                    m_axi.rready <= 1'b1;
                    r_state <= RD_DATA;
                end
                RD_DATA: if (m_axi.rvalid) begin
                    o_mem_valid <= w_in_range;
                    o_mem_data <= w_in_range ? m_axi.rdata : '0;
                    o_mem_err <= w_in_range && ((m_axi.rresp != RESP_OKAY) || (m_axi.rlast != w_final));
                    if (w_in_range) r_beat <= r_beat + 8'd1;
                    if (m_axi.rlast) begin
                        m_axi.rready <= 1'b0;
                        r_state <= DONE;
                    end
                end
                WR_REQ: begin
                    if (m_axi.awready) m_axi.awvalid <= 1'b0;
                    if (m_axi.wready) begin
                        m_axi.wvalid <= 1'b0;
                        m_axi.wlast <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        m_axi.bready <= 1'b1;
                        r_state <= WR_RESP;
                    end
                end
                WR_RESP: if (m_axi.bvalid) begin
                    m_axi.bready <= 1'b0;
                    o_mem_valid <= 1'b1;
                    o_mem_err <= m_axi.bresp != RESP_OKAY;
                    r_state <= DONE;
                end
                DONE: begin
                    o_mem_rdy <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/omi_axi_bridge.md
# omi_axi_bridge

Converts the cache controller's memory-side OMI request port into AXI4 master transactions on the external memory bus. It sits directly downstream of the cache: the cache's `o_mem_*` outputs drive this block's `i_mem_*` inputs, and this block's `o_mem_*` outputs drive the cache's `i_mem_*` inputs. It handles one outstanding OMI request at a time: incrementing read bursts of 1..LEN_MAX beats, and single-beat byte-masked writes (the cache is write-through).

## Interface
- ADDR_WIDTH, 10, byte address width on the OMI and AXI sides
- DATA_WIDTH, 32, data width; DATA_WIDTH/8 byte lanes
- LEN_MAX, 4, maximum read beats per request
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  reset; synchronous, active-high
- i_mem_req / i_mem_wen  in  1 / 1  OMI request; write when `i_mem_wen`=1
- i_mem_addr  in  ADDR_WIDTH  byte address, aligned to DATA_WIDTH/8
- i_mem_ben / i_mem_data  in  DATA_WIDTH/8 / DATA_WIDTH  write byte enables and data
- i_mem_len  in  8  beat count; 0 is treated as 1
- o_mem_rdy  out  1  idle and able to accept a request
- o_mem_valid / o_mem_data  out  1 / DATA_WIDTH  per-beat read data or write-completion pulse
- o_mem_err  out  1  error flag for the current beat; meaningful only while `o_mem_valid`=1
- m_axi_ar{addr,len,size,burst,valid} out / m_axi_arready in  AXI4 read-address channel
- m_axi_r{data,resp,last,valid} in / m_axi_rready out  AXI4 read-data channel
- m_axi_aw{addr,len,size,burst,valid} out / m_axi_awready in  AXI4 write-address channel
- m_axi_w{data,strb,last,valid} out / m_axi_wready in  AXI4 write-data channel
- m_axi_b{resp,valid} in / m_axi_bready out  AXI4 write-response channel

## Operation
- Acceptance: the request is accepted on the edge where `i_mem_req && o_mem_rdy`. The address (low log2(DATA_WIDTH/8) bits forced to 0), wen, ben, data and len (clamped to 1..LEN_MAX) are registered.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE → RD_ADDR on a read acceptance; IDLE → WR_REQ on a write acceptance.
- RD_ADDR: `arvalid`=1, `arlen`=len−1, `arsize`=log2(DATA_WIDTH/8), `arburst`=INCR. Move to RD_DATA on the AR handshake.
- RD_DATA: `rready`=1, with no backpressure. Each R handshake produces one `o_mem_valid` pulse carrying `rdata`. A beat counter increments per beat. On `rlast` the block goes to DONE.
- Read error: `o_mem_err`=1 on a beat if `rresp` is not OKAY, or if `rlast` disagrees with the beat counter. If `rlast` arrives early, the burst ends. If the counter reaches len without `rlast`, the block keeps consuming beats until `rlast` but suppresses `o_mem_valid` for the extra beats.
- WR_REQ: `awvalid` and `wvalid` both assert, with `awlen`=0, `wlast`=1, `wstrb`=ben. Each valid drops independently on its own handshake. When both handshakes are done, move to WR_RESP.
- WR_RESP: `bready`=1. On the B handshake, pulse `o_mem_valid` with `o_mem_data`=0 and `o_mem_err`=(`bresp`≠OKAY), then go to DONE.
- DONE → IDLE after one cycle.
- Output rules: `o_mem_data`=0 whenever `o_mem_valid`=0. `o_mem_valid` is never high while `o_mem_rdy`=1.
- Reset, including mid-burst: return to IDLE and drive every output to its reset value. The AXI slave shares this reset.
- Reset values: `o_mem_rdy`=1. All other outputs are 0: valids, readies, `o_mem_data`, `o_mem_err` and AXI payloads.

## Timing
- All outputs are registered.
- Acceptance at edge E: in cycle E+1, `o_mem_rdy`=0 and `arvalid` (or `awvalid`/`wvalid`) is 1.
- A simultaneous AW and W handshake in the same cycle goes directly to WR_RESP on the next cycle.
- R handshake at edge N: `o_mem_valid`=1 with the data during cycle N+1.
- `o_mem_rdy` returns to 1 one cycle after the last `o_mem_valid` pulse (the DONE cycle).
- Back-to-back turnaround: minimum 2 idle-side cycles between requests.
- Best-case read latency, acceptance to first data: 3 cycles (arready=1, rvalid the cycle after AR).

## Structure
- Shared package `omi_axi_pkg` holds:
  - the state enum;
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00;
  - a `size_of(DATA_WIDTH)` function.
- Single module `omi_axi_bridge`. The beat counter and channel handshake tracking are inline; no sub-module.

## Test plan
- Read of len=4 at 0x040, arready=1, 4 consecutive R beats 0xA0..0xA3 with rlast on the 4th → `araddr`=0x040, `arlen`=3; 4 valid pulses 0xA0..0xA3 on consecutive cycles; `o_mem_rdy` high one cycle after the last pulse.
- Write to 0x00C, ben=4'b0011, data=0xDEADBEEF; awready held 3 cycles after wready → W completes first and AW later; one `o_mem_valid` pulse with data 0; `wstrb`=0011.
- Read len=2 with `rresp`=SLVERR on beat 1 → `o_mem_err`=1 on the first pulse only.
- Read len=4 with rlast on beat 2 → 2 pulses, `o_mem_err`=1 on the 2nd, return to IDLE.
- Reset asserted during RD_DATA after 1 beat → next cycle `o_mem_rdy`=1, `rready`=0, `o_mem_valid`=0; a subsequent read completes normally.
- `i_mem_len`=0 and `i_mem_len`=9 → `arlen`=0 and `arlen`=3 respectively.
